// File: rtl/nios2os_avalon_st_packet_arbiter.sv
// ---------------------------------------------------------------------------
// nios2os_avalon_st_packet_arbiter
//
// Purpose:
//   Packet-granular round-robin arbiter. NUM_IN Avalon-ST sources share one
//   Avalon-ST sink, which is the 32-bit streaming timing adapter in front of
//   the UDP datapath. A source is granted at start-of-packet. It keeps the
//   grant until its end-of-packet beat is accepted, so packets from
//   different sources never interleave. Grant state is registered. The
//   payload path and the ready path form a zero-latency combinational mux.
//
// Optional feature (compile-time macro):
//   NIOS2OS_ARB_ORPHAN_DROP_EN
//     Defined   : In IDLE, a beat with valid=1 and SOP=0 is an orphan. It is
//                 acknowledged (in_ready=1) and discarded. Orphans never
//                 take part in arbitration.
//     Undefined : Any valid source in IDLE is a request, with or without
//                 SOP. Every in_ready is 0 in IDLE.
//
// Ports:
//   clk, reset               single clock; synchronous active-high reset
//   in_valid/in_ready        per-source handshake (NUM_IN bits each)
//   in_data/in_error/
//   in_empty                 flat buses; source i sits at [i*W +: W]
//   in_startofpacket/
//   in_endofpacket           per-source framing
//   out_ready                sink ready (ready latency 0)
//   out_valid, out_data,
//   out_error, out_empty,
//   out_startofpacket,
//   out_endofpacket          muxed stream of the granted source
//   out_channel              index of the granted source
//   busy                     high while a packet is in flight
// ---------------------------------------------------------------------------
module nios2os_avalon_st_packet_arbiter #(
    parameter int NUM_IN  = 2,
    parameter int DATA_W  = 32,
    parameter int ERROR_W = 6,
    parameter int EMPTY_W = 2,
    parameter int CH_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN*ERROR_W-1:0] in_error,
    input  logic [NUM_IN-1:0]         in_startofpacket,
    input  logic [NUM_IN-1:0]         in_endofpacket,
    input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ERROR_W-1:0]        out_error,
    output logic                      out_startofpacket,
    output logic                      out_endofpacket,
    output logic [EMPTY_W-1:0]        out_empty,
    output logic [CH_W-1:0]           out_channel,
    output logic                      busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_q,  last_d;
    logic              busy_q,  busy_d;

    // Unpacked views of the flat per-source buses.
    logic [DATA_W-1:0]  data_arr  [NUM_IN];
    logic [ERROR_W-1:0] error_arr [NUM_IN];
    logic [EMPTY_W-1:0] empty_arr [NUM_IN];
    logic [NUM_IN-1:0]  req;
    logic [NUM_IN-1:0]  orphan;
    logic [NUM_IN-1:0]  is_granted;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
            assign data_arr[gi]   = in_data[gi*DATA_W +: DATA_W];
            assign error_arr[gi]  = in_error[gi*ERROR_W +: ERROR_W];
            assign empty_arr[gi]  = in_empty[gi*EMPTY_W +: EMPTY_W];
            // One-hot decode of the grant. This avoids indexing with a
            // grant value that may be wider than the source index range.
            assign is_granted[gi] = (grant_q == CH_W'(gi));
`ifdef NIOS2OS_ARB_ORPHAN_DROP_EN
            assign req[gi]    = in_valid[gi] & in_startofpacket[gi];
            assign orphan[gi] = in_valid[gi] & ~in_startofpacket[gi];
`else
            assign req[gi]    = in_valid[gi];
            assign orphan[gi] = 1'b0;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search: first requester among last+1, last+2, ...
    // (mod NUM_IN). last_q is always < NUM_IN, so one wrap subtraction
    // is enough.
    // ------------------------------------------------------------------
    logic            found;
    logic [CH_W-1:0] winner;

    always_comb begin
        int   idx;
        logic cand;
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            cand = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (i == idx) begin
                    cand = req[i];
                end
            end
            if (!found && cand) begin
                found  = 1'b1;
                winner = CH_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload mux. It defaults to source 0, so the outputs stay defined
    // for any grant value.
    // ------------------------------------------------------------------
    logic sel_valid;

    always_comb begin
        sel_valid         = in_valid[0];
        out_data          = data_arr[0];
        out_error         = error_arr[0];
        out_empty         = empty_arr[0];
        out_startofpacket = in_startofpacket[0];
        out_endofpacket   = in_endofpacket[0];
        for (int i = 0; i < NUM_IN; i++) begin
            if (is_granted[i]) begin
                sel_valid         = in_valid[i];
                out_data          = data_arr[i];
                out_error         = error_arr[i];
                out_empty         = empty_arr[i];
                out_startofpacket = in_startofpacket[i];
                out_endofpacket   = in_endofpacket[i];
            end
        end
    end

    assign out_valid   = (state_q == BUSY) & sel_valid;
    assign out_channel = grant_q;
    assign busy        = busy_q;

    // Ready routing. In BUSY, ready goes only to the granted source. In
    // IDLE, ready goes only to orphans, and only when orphan dropping is
    // compiled in.
    always_comb begin
        in_ready = '0;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_IN; i++) begin
                in_ready[i] = is_granted[i] & out_ready;
            end
        end else begin
            in_ready = orphan;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = winner;
                    last_d  = winner;
                end
            end
            BUSY: begin
                // The packet ends only when its EOP beat is actually accepted.
                if (out_valid && out_ready && out_endofpacket) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
    end

    // last resets to NUM_IN-1, so the first arbitration favours source 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CH_W'(NUM_IN - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

endmodule
